// File: rtl/hamming74_enc_sched.sv
// Round-robin scheduler that shares one Hamming(7,4) encoder among N_REQ byte
// requesters. Each granted byte is emitted as two 9-bit codewords on a single
// valid/ready stream: low nibble first (flag 0), then high nibble (flag 1).
module hamming74_enc_sched #(
  parameter int unsigned N_REQ = 4,
  localparam int unsigned SRC_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [N_REQ-1:0]     i_req_valid,
  input  logic [8*N_REQ-1:0]   i_req_data,
  output logic [N_REQ-1:0]     o_req_ready,
  output logic                 o_cw_valid,
  output logic [8:0]           o_cw,
  output logic [SRC_W-1:0]     o_cw_src,
  input  logic                 i_cw_ready,
  output logic                 o_busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2
  } state_t;

  state_t           state;
  logic [SRC_W-1:0] last_grant;
  logic [3:0]       hi_nib;

  logic             hi_found;
  logic             lo_found;
  logic [SRC_W-1:0] win_hi;
  logic [SRC_W-1:0] win_lo;
  logic             any_valid;
  logic [SRC_W-1:0] winner;
  logic [7:0]       sel_byte;

  // Hamming(7,4) codeword with overall parity in bit 7 and end-of-byte flag in bit 8
  function automatic logic [8:0] encode(input logic [3:0] d, input logic f);
    logic [6:0] c;
    c[0] = d[0] ^ d[1] ^ d[3];
    c[1] = d[0] ^ d[2] ^ d[3];
    c[2] = d[0];
    c[3] = d[1] ^ d[2] ^ d[3];
    c[4] = d[1];
    c[5] = d[2];
    c[6] = d[3];
    return {f, ^c, c};
  endfunction

  // Round-robin search: lowest valid index above last_grant, else lowest valid overall
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    win_hi   = '0;
    win_lo   = '0;
    for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
      if (i_req_valid[k]) begin
        lo_found = 1'b1;
        win_lo   = SRC_W'(k);
        if (SRC_W'(k) > last_grant) begin
          hi_found = 1'b1;
          win_hi   = SRC_W'(k);
        end
      end
    end
    any_valid = lo_found;
    winner    = hi_found ? win_hi : win_lo;
  end

  // One-hot accept strobe and winner byte mux; strobes only while idle
  always_comb begin
    o_req_ready = '0;
    sel_byte    = '0;
    for (int k = 0; k < int'(N_REQ); k++) begin
      if (winner == SRC_W'(k)) begin
        sel_byte       = i_req_data[8*k +: 8];
        o_req_ready[k] = (state == IDLE) && any_valid;
      end
    end
  end

  // Scheduler FSM with registered codeword stream outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      last_grant <= SRC_W'(N_REQ - 1);
      hi_nib     <= '0;
      o_cw_valid <= 1'b0;
      o_cw       <= '0;
      o_cw_src   <= '0;
      o_busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            hi_nib     <= sel_byte[7:4];
            o_cw_src   <= winner;
            last_grant <= winner;
            o_cw       <= encode(sel_byte[3:0], 1'b0);
            o_cw_valid <= 1'b1;
            o_busy     <= 1'b1;
            state      <= LO;
          end
        end
        LO: begin
          if (o_cw_valid && i_cw_ready) begin
            o_cw  <= encode(hi_nib, 1'b1);
            state <= HI;
          end
        end
        HI: begin
          if (o_cw_valid && i_cw_ready) begin
            o_cw_valid <= 1'b0;
            o_busy     <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          o_cw_valid <= 1'b0;
          o_busy     <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hamming74_enc_sched.sv
// Directed bench for hamming74_enc_sched (N_REQ=4) with hand-computed codewords.
module tb_hamming74_enc_sched;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        cw_valid;
  logic [8:0]  cw;
  logic [1:0]  cw_src;
  logic        cw_ready;
  logic        busy;

  int checks = 0;
  int errors = 0;

  hamming74_enc_sched #(.N_REQ(4)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req_valid (req_valid),
    .i_req_data  (req_data),
    .o_req_ready (req_ready),
    .o_cw_valid  (cw_valid),
    .o_cw        (cw),
    .o_cw_src    (cw_src),
    .i_cw_ready  (cw_ready),
    .o_busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; sample point is 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (cw_valid !== 1'b0 || cw !== 9'h000 || cw_src !== 2'd0 || busy !== 1'b0 || req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL reset: valid=%b cw=%h src=%0d busy=%b ready=%b, required 0 000 0 0 0000",
               cw_valid, cw, cw_src, busy, req_ready);
    end
  endtask

  task automatic test_basic_b5();
    req_data  = 32'h0000_00B5;
    req_valid = 4'b0001;
    cw_ready  = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++; $display("FAIL b5_grant: ready=%b required 0001", req_ready);
    end
    tick();
    req_valid = 4'b0000;
    checks++;
    if (cw_valid !== 1'b1 || cw !== 9'h02D || cw_src !== 2'd0 || busy !== 1'b1 || req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL b5_lo: valid=%b cw=%h src=%0d busy=%b ready=%b, required 1 02d 0 1 0000",
               cw_valid, cw, cw_src, busy, req_ready);
    end
    tick();
    checks++;
    if (cw_valid !== 1'b1 || cw !== 9'h155 || cw_src !== 2'd0) begin
      errors++; $display("FAIL b5_hi: valid=%b cw=%h src=%0d, required 1 155 0", cw_valid, cw, cw_src);
    end
    tick();
    checks++;
    if (cw_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL b5_idle: valid=%b busy=%b, required 0 0", cw_valid, busy);
    end
  endtask

  task automatic test_extremes_f0();
    req_data  = 32'h00F0_0000;
    req_valid = 4'b0100;
    cw_ready  = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++; $display("FAIL f0_grant: ready=%b required 0100", req_ready);
    end
    tick();
    req_valid = 4'b0000;
    checks++;
    if (cw_valid !== 1'b1 || cw !== 9'h000 || cw_src !== 2'd2) begin
      errors++; $display("FAIL f0_lo: valid=%b cw=%h src=%0d, required 1 000 2", cw_valid, cw, cw_src);
    end
    tick();
    checks++;
    if (cw_valid !== 1'b1 || cw !== 9'h1FF || cw_src !== 2'd2) begin
      errors++; $display("FAIL f0_hi: valid=%b cw=%h src=%0d, required 1 1ff 2", cw_valid, cw, cw_src);
    end
    tick();
    checks++;
    if (cw_valid !== 1'b0) begin
      errors++; $display("FAIL f0_idle: valid=%b required 0", cw_valid);
    end
  endtask

  task automatic test_fairness();
    logic [8:0] exp_lo [4];
    logic [8:0] exp_hi [4];
    exp_lo[0] = 9'h099; exp_hi[0] = 9'h187;
    exp_lo[1] = 9'h0AA; exp_hi[1] = 9'h11E;
    exp_lo[2] = 9'h04B; exp_hi[2] = 9'h1B4;
    exp_lo[3] = 9'h0E1; exp_hi[3] = 9'h1CC;
    do_reset();
    req_data  = 32'h9C78_3412;
    req_valid = 4'b1111;
    cw_ready  = 1'b1;
    for (int n = 0; n < 5; n++) begin
      int k;
      k = n % 4;
      #1;
      checks++;
      if (req_ready !== 4'(1 << k)) begin
        errors++; $display("FAIL fair_grant%0d: ready=%b required %b", n, req_ready, 4'(1 << k));
      end
      tick();
      checks++;
      if (cw_valid !== 1'b1 || cw !== exp_lo[k] || cw_src !== 2'(k) || req_ready !== 4'b0000) begin
        errors++;
        $display("FAIL fair_lo%0d: valid=%b cw=%h src=%0d ready=%b, required 1 %h %0d 0000",
                 n, cw_valid, cw, cw_src, req_ready, exp_lo[k], k);
      end
      tick();
      checks++;
      if (cw_valid !== 1'b1 || cw !== exp_hi[k] || cw_src !== 2'(k)) begin
        errors++;
        $display("FAIL fair_hi%0d: valid=%b cw=%h src=%0d, required 1 %h %0d",
                 n, cw_valid, cw, cw_src, exp_hi[k], k);
      end
      tick();
    end
    req_valid = 4'b0000;
    tick();
  endtask

  task automatic test_backpressure();
    req_data  = 32'h0000_3400;
    req_valid = 4'b0010;
    cw_ready  = 1'b0;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++; $display("FAIL bp_grant: ready=%b required 0010", req_ready);
    end
    tick();
    req_valid = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      checks++;
      if (cw_valid !== 1'b1 || cw !== 9'h0AA || cw_src !== 2'd1 || req_ready !== 4'b0000) begin
        errors++;
        $display("FAIL bp_hold%0d: valid=%b cw=%h src=%0d ready=%b, required 1 0aa 1 0000",
                 n, cw_valid, cw, cw_src, req_ready);
      end
      tick();
    end
    req_valid = 4'b0000;
    cw_ready  = 1'b1;
    tick();
    checks++;
    if (cw_valid !== 1'b1 || cw !== 9'h11E || cw_src !== 2'd1) begin
      errors++; $display("FAIL bp_hi: valid=%b cw=%h src=%0d, required 1 11e 1", cw_valid, cw, cw_src);
    end
    tick();
    checks++;
    if (cw_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL bp_idle: valid=%b busy=%b, required 0 0", cw_valid, busy);
    end
  endtask

  task automatic test_pointer_wrap();
    req_data  = 32'h9C00_0000;
    req_valid = 4'b1000;
    cw_ready  = 1'b1;
    tick();
    tick();
    tick();
    req_data  = 32'hC300_5A00;
    req_valid = 4'b1010;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++; $display("FAIL wrap_grant1: ready=%b required 0010", req_ready);
    end
    tick();
    checks++;
    if (cw !== 9'h0D2 || cw_src !== 2'd1) begin
      errors++; $display("FAIL wrap_lo1: cw=%h src=%0d, required 0d2 1", cw, cw_src);
    end
    tick();
    checks++;
    if (cw !== 9'h12D || cw_src !== 2'd1) begin
      errors++; $display("FAIL wrap_hi1: cw=%h src=%0d, required 12d 1", cw, cw_src);
    end
    tick();
    checks++;
    if (req_ready !== 4'b1000) begin
      errors++; $display("FAIL wrap_grant3: ready=%b required 1000", req_ready);
    end
    tick();
    req_valid = 4'b0000;
    checks++;
    if (cw !== 9'h01E || cw_src !== 2'd3) begin
      errors++; $display("FAIL wrap_lo3: cw=%h src=%0d, required 01e 3", cw, cw_src);
    end
    tick();
    checks++;
    if (cw !== 9'h1E1 || cw_src !== 2'd3) begin
      errors++; $display("FAIL wrap_hi3: cw=%h src=%0d, required 1e1 3", cw, cw_src);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    req_data  = 32'h0012_0000;
    req_valid = 4'b0100;
    cw_ready  = 1'b1;
    tick();
    req_valid = 4'b0000;
    tick();
    cw_ready  = 1'b0;
    checks++;
    if (cw_valid !== 1'b1 || cw !== 9'h187 || cw_src !== 2'd2) begin
      errors++; $display("FAIL rmid_hi: valid=%b cw=%h src=%0d, required 1 187 2", cw_valid, cw, cw_src);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (cw_valid !== 1'b0 || busy !== 1'b0 || cw !== 9'h000 || cw_src !== 2'd0) begin
      errors++;
      $display("FAIL rmid_reset: valid=%b busy=%b cw=%h src=%0d, required 0 0 000 0",
               cw_valid, busy, cw, cw_src);
    end
    cw_ready = 1'b1;
    tick();
    checks++;
    if (cw_valid !== 1'b0) begin
      errors++; $display("FAIL rmid_nohi: valid=%b required 0", cw_valid);
    end
    req_data  = 32'h9C78_3412;
    req_valid = 4'b1111;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++; $display("FAIL rmid_grant: ready=%b required 0001", req_ready);
    end
    tick();
    req_valid = 4'b0000;
    checks++;
    if (cw !== 9'h099 || cw_src !== 2'd0) begin
      errors++; $display("FAIL rmid_lo: cw=%h src=%0d, required 099 0", cw, cw_src);
    end
    tick();
    tick();
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 4'b0000;
    req_data  = 32'h0;
    cw_ready  = 1'b0;
    test_reset();
    test_basic_b5();
    test_extremes_f0();
    test_fairness();
    test_backpressure();
    test_pointer_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
